// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB target: FSM state encoding, byte framing and line-drive constants.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID,
    ST_ID_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_RD_DATA,
    ST_RD_NA,
    ST_WAIT_STOP
  } sccb_state_e;

  localparam int SCCB_BITS_PER_BYTE = 8;

  // siod_oe values: asserting pulls the open-drain line low
  localparam logic LINE_ACK  = 1'b1;
  localparam logic LINE_NACK = 1'b0;

  localparam logic [7:0] SCCB_DEVICE_ID_DEFAULT = 8'h42;

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizes SIOC/SIOD into the clk domain and produces registered
// SIOC edge and START/STOP condition pulses plus the aligned SIOD level.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sioc_i,
  input  logic siod_i,
  output logic siod_o,
  output logic sioc_rise_o,
  output logic sioc_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] sioc_sync_q;
  logic [SYNC_STAGES-1:0] siod_sync_q;
  logic sioc_prev_q, siod_prev_q;
  logic sioc_s, siod_s;

  assign sioc_s = sioc_sync_q[SYNC_STAGES-1];
  assign siod_s = siod_sync_q[SYNC_STAGES-1];

  // Idle bus is pulled high, so reset to 1 to avoid a phantom edge after reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sioc_sync_q <= '1;
      siod_sync_q <= '1;
      sioc_prev_q <= 1'b1;
      siod_prev_q <= 1'b1;
      sioc_rise_o <= 1'b0;
      sioc_fall_o <= 1'b0;
      start_o     <= 1'b0;
      stop_o      <= 1'b0;
    end else begin
      sioc_sync_q <= {sioc_sync_q[SYNC_STAGES-2:0], sioc_i};
      siod_sync_q <= {siod_sync_q[SYNC_STAGES-2:0], siod_i};
      sioc_prev_q <= sioc_s;
      siod_prev_q <= siod_s;
      sioc_rise_o <= sioc_s & ~sioc_prev_q;
      sioc_fall_o <= ~sioc_s & sioc_prev_q;
      start_o     <= ~siod_s & siod_prev_q & sioc_s & sioc_prev_q;
      stop_o      <= siod_s & ~siod_prev_q & sioc_s & sioc_prev_q;
    end
  end

  assign siod_o = siod_prev_q;

endmodule

// File: rtl/sccb_target.sv
// SCCB target emulating the OV7670 register port with a 256x8 register image.
// Define SCCB_TARGET_READ_EN to enable 2-phase read (RD_DATA/RD_NA); otherwise reads are NACKed.
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID   = SCCB_DEVICE_ID_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sioc_in,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       reg_wr_valid,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       busy,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);

  sccb_state_e state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        oe_q, oe_d;
  logic        wr_en;
  logic [7:0]  regs_q [256];
  logic        siod_s, sioc_rise, sioc_fall, start, stop;
  logic        last_bit;
  logic        id_ok;

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .sioc_i      (sioc_in),
    .siod_i      (siod_in),
    .siod_o      (siod_s),
    .sioc_rise_o (sioc_rise),
    .sioc_fall_o (sioc_fall),
    .start_o     (start),
    .stop_o      (stop)
  );

  assign last_bit = (bit_cnt_q == 3'(SCCB_BITS_PER_BYTE - 1));

`ifdef SCCB_TARGET_READ_EN
  assign id_ok = (shift_d[7:1] == DEVICE_ID[7:1]);
`else
  assign id_ok = (shift_d[7:1] == DEVICE_ID[7:1]) && !shift_d[0];
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    wr_en     = 1'b0;
    if (start) begin
      state_d   = ST_ID;
      bit_cnt_d = '0;
      oe_d      = LINE_NACK;
    end else if (stop) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      oe_d      = LINE_NACK;
    end else begin
      case (state_q)
        ST_ID, ST_SUB, ST_DATA: begin
          if (sioc_rise) begin
            shift_d   = {shift_q[6:0], siod_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              case (state_q)
                ST_ID:   state_d = id_ok ? ST_ID_ACK : ST_WAIT_STOP;
                ST_SUB: begin
                  ptr_d   = shift_d;
                  state_d = ST_SUB_ACK;
                end
                default: state_d = ST_DATA_ACK;
              endcase
            end
          end
        end
        // First SIOC fall after bit 8 starts the ACK drive, the next one ends it
        ST_ID_ACK, ST_SUB_ACK, ST_DATA_ACK: begin
          if (sioc_fall) begin
            if (!oe_q) begin
              oe_d = LINE_ACK;
            end else begin
              oe_d = LINE_NACK;
              case (state_q)
                ST_ID_ACK: begin
                  state_d = ST_SUB;
`ifdef SCCB_TARGET_READ_EN
                  if (shift_q[0]) begin
                    state_d   = ST_RD_DATA;
                    shift_d   = regs_q[ptr_q];
                    bit_cnt_d = '0;
                    oe_d      = ~shift_d[7];
                  end
`endif
                end
                ST_SUB_ACK: state_d = ST_DATA;
                default: begin
                  state_d = ST_WAIT_STOP;
                  wr_en   = 1'b1;
                end
              endcase
            end
          end
        end
`ifdef SCCB_TARGET_READ_EN
        ST_RD_DATA: begin
          if (sioc_fall) begin
            if (last_bit) begin
              oe_d      = LINE_NACK;
              bit_cnt_d = '0;
              state_d   = ST_RD_NA;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              shift_d   = {shift_q[6:0], 1'b0};
              oe_d      = ~shift_d[7];
            end
          end
        end
        ST_RD_NA: begin
          if (sioc_rise) state_d = ST_WAIT_STOP;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      ptr_q        <= '0;
      oe_q         <= LINE_NACK;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= '0;
      reg_wr_data  <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ptr_q        <= ptr_d;
      oe_q         <= oe_d;
      reg_wr_valid <= wr_en;
      if (wr_en) begin
        reg_wr_addr <= ptr_q;
        reg_wr_data <= shift_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[ptr_q] <= shift_q;
    end
  end

  // START/STOP must release the line in the same cycle they are detected
  assign siod_oe  = oe_q & ~start & ~stop;
  assign busy     = (state_q != ST_IDLE);
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: bit-banged SCCB master on an open-drain SIOD model.
module tb_sccb_target;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sioc;
  logic       sda_m;
  logic       siod;
  logic       siod_oe;
  logic       reg_wr_valid;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       busy;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_data;

  int n_cmp = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  logic [7:0] last_addr, last_data;
  logic oe_seen = 1'b0;

  assign siod = sda_m & ~siod_oe;

  always #5 clk = ~clk;

  sccb_target dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sioc_in      (sioc),
    .siod_in      (siod),
    .siod_oe      (siod_oe),
    .reg_wr_valid (reg_wr_valid),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .busy         (busy),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  always @(negedge clk) begin
    if (reg_wr_valid) begin
      wr_cnt++;
      last_addr = reg_wr_addr;
      last_data = reg_wr_data;
    end
    if (siod_oe) oe_seen = 1'b1;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic send_start();
    sda_m = 1'b1; wait_q();
    sioc  = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    sioc  = 1'b0; wait_q();
  endtask

  task automatic send_stop();
    sda_m = 1'b0; wait_q();
    sioc  = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack, output logic rel);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_q();
      sioc  = 1'b1; wait_q(); wait_q();
      sioc  = 1'b0; wait_q();
    end
    sda_m = 1'b1; wait_q();
    sioc  = 1'b1; wait_q();
    ack   = siod_oe;
    wait_q();
    sioc  = 1'b0; wait_q();
    rel   = ~siod_oe;
  endtask

  task automatic read_byte(output logic [7:0] b);
    sda_m = 1'b1;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      wait_q();
      sioc = 1'b1; wait_q();
      b = {b[6:0], siod};
      wait_q();
      sioc = 1'b0;
    end
    wait_q();
    sioc = 1'b1; wait_q(); wait_q();
    sioc = 1'b0; wait_q();
  endtask

  task automatic apply_reset();
    sioc = 1'b1; sda_m = 1'b1; dbg_addr = 8'h00;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (siod_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_oe got %b exp 0", siod_oe); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if ({reg_wr_valid, reg_wr_addr, reg_wr_data} !== 17'h0) begin
      n_fail++; $display("[TB] FAIL reset_wr got %b/%h/%h exp 0/00/00", reg_wr_valid, reg_wr_addr, reg_wr_data);
    end
    dbg_addr = 8'h12; #1;
    n_cmp++; if (dbg_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_reg12 got %h exp 00", dbg_data); end
  endtask

  task automatic test_write();
    logic a0, a1, a2, r;
    wr_cnt = 0;
    send_start();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_busy_start got %b exp 1", busy); end
    send_byte(8'h42, a0, r);
    send_byte(8'h12, a1, r);
    send_byte(8'h80, a2, r);
    n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("[TB] FAIL wr_acks got %b exp 111", {a0, a1, a2}); end
    n_cmp++; if (r !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_ack_release got %b exp 1", r); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_busy_prestop got %b exp 1", busy); end
    send_stop();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_busy_stop got %b exp 0", busy); end
    n_cmp++; if (wr_cnt !== 1) begin n_fail++; $display("[TB] FAIL wr_count got %0d exp 1", wr_cnt); end
    n_cmp++; if ({last_addr, last_data} !== 16'h1280) begin
      n_fail++; $display("[TB] FAIL wr_addr_data got %h/%h exp 12/80", last_addr, last_data);
    end
    dbg_addr = 8'h12; #1;
    n_cmp++; if (dbg_data !== 8'h80) begin n_fail++; $display("[TB] FAIL wr_reg12 got %h exp 80", dbg_data); end
  endtask

  task automatic test_wrong_id();
    logic a, r;
    wr_cnt = 0; oe_seen = 1'b0;
    send_start();
    send_byte(8'h60, a, r);
    send_byte(8'h12, a, r);
    send_byte(8'h55, a, r);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL wid_busy got %b exp 1", busy); end
    send_stop();
    n_cmp++; if (oe_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL wid_oe_seen got %b exp 0", oe_seen); end
    n_cmp++; if (wr_cnt !== 0) begin n_fail++; $display("[TB] FAIL wid_count got %0d exp 0", wr_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL wid_busy_stop got %b exp 0", busy); end
    dbg_addr = 8'h12; #1;
    n_cmp++; if (dbg_data !== 8'h80) begin n_fail++; $display("[TB] FAIL wid_reg12 got %h exp 80", dbg_data); end
  endtask

  task automatic test_read();
    logic a, r;
    logic [7:0] rd;
    send_start();
    send_byte(8'h42, a, r); send_byte(8'h0A, a, r); send_byte(8'h5C, a, r);
    send_stop();
    send_start();
    send_byte(8'h42, a, r); send_byte(8'h0A, a, r);
    send_stop();
    send_start();
    send_byte(8'h43, a, r);
`ifdef SCCB_TARGET_READ_EN
    n_cmp++; if (a !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_id_ack got %b exp 1", a); end
    read_byte(rd);
    n_cmp++; if (rd !== 8'h5C) begin n_fail++; $display("[TB] FAIL rd_data got %h exp 5c", rd); end
`else
    rd = 8'h00;
    n_cmp++; if (a !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_id_nack got %b exp 0", a); end
`endif
    send_stop();
    n_cmp++; if (siod_oe !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rd_idle got oe=%b busy=%b exp 0/0 (rd=%h)", siod_oe, busy, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic a, r;
    wr_cnt = 0;
    send_start();
    send_byte(8'h42, a, r); send_byte(8'h12, a, r);
    send_start();
    send_byte(8'h42, a, r); send_byte(8'h13, a, r); send_byte(8'h01, a, r);
    send_stop();
    n_cmp++; if (wr_cnt !== 1) begin n_fail++; $display("[TB] FAIL rs_count got %0d exp 1", wr_cnt); end
    n_cmp++; if ({last_addr, last_data} !== 16'h1301) begin
      n_fail++; $display("[TB] FAIL rs_addr_data got %h/%h exp 13/01", last_addr, last_data);
    end
    dbg_addr = 8'h12; #1;
    n_cmp++; if (dbg_data !== 8'h80) begin n_fail++; $display("[TB] FAIL rs_reg12 got %h exp 80", dbg_data); end
  endtask

  task automatic test_reset_mid();
    logic a, r;
    logic [7:0] d;
    wr_cnt = 0;
    d = 8'hA5;
    send_start();
    send_byte(8'h42, a, r); send_byte(8'h13, a, r);
    for (int i = 7; i >= 4; i--) begin
      sda_m = d[i]; wait_q();
      sioc  = 1'b1; wait_q();
      if (i > 4) begin wait_q(); sioc = 1'b0; wait_q(); end
    end
    rst_n = 1'b0; #1;
    n_cmp++; if (siod_oe !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rm_async got oe=%b busy=%b exp 0/0", siod_oe, busy);
    end
    dbg_addr = 8'h13; #1;
    n_cmp++; if (dbg_data !== 8'h00) begin n_fail++; $display("[TB] FAIL rm_reg13 got %h exp 00", dbg_data); end
    repeat (5) @(negedge clk);
    sioc = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (wr_cnt !== 0) begin n_fail++; $display("[TB] FAIL rm_count got %0d exp 0", wr_cnt); end
    test_write();
  endtask

  task automatic test_extra_byte();
    logic a0, a1, a2, a3, r;
    wr_cnt = 0;
    send_start();
    send_byte(8'h42, a0, r); send_byte(8'h20, a1, r);
    send_byte(8'h11, a2, r); send_byte(8'h22, a3, r);
    send_stop();
    n_cmp++; if ({a0, a1, a2, a3} !== 4'b1110) begin
      n_fail++; $display("[TB] FAIL xb_acks got %b exp 1110", {a0, a1, a2, a3});
    end
    n_cmp++; if (wr_cnt !== 1) begin n_fail++; $display("[TB] FAIL xb_count got %0d exp 1", wr_cnt); end
    dbg_addr = 8'h20; #1;
    n_cmp++; if (dbg_data !== 8'h11) begin n_fail++; $display("[TB] FAIL xb_reg20 got %h exp 11", dbg_data); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_id();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_extra_byte();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
